// File: rtl/factorial_bcd_if.sv
// Handshake bundle for the factorial engine: start request and operand in,
// state, completion flag, binary result and its BCD rendering out.
interface factorial_bcd_if #(
    parameter int SIZE = 8
);
    logic            go;
    logic [SIZE-1:0] n;
    logic [2:0]      curr_state;
    logic            done;
    logic [SIZE-1:0] result;
    logic [31:0]     bcd_out;

    modport master (
        output go,
        output n,
        input  curr_state,
        input  done,
        input  result,
        input  bcd_out
    );

    modport slave (
        input  go,
        input  n,
        output curr_state,
        output done,
        output result,
        output bcd_out
    );
endinterface

// File: rtl/factorial_bcd.sv
// Iterative factorial engine (multiply-decrement loop) with a combinational
// double-dabble converter presenting the result as 8 packed BCD digits.
module factorial_bcd #(
    parameter int SIZE = 8
) (
    input logic            clk,
    input logic            rst_n,
    factorial_bcd_if.slave bus
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] MULT = 3'd1;
    localparam logic [2:0] DONE = 3'd2;

    localparam logic [SIZE-1:0] ONE = SIZE'(1);

    logic [2:0]      state;
    logic [2:0]      state_nxt;
    logic [SIZE-1:0] acc;
    logic [SIZE-1:0] cnt;
    logic [SIZE-1:0] prod;
    logic            last_step;

    // Shift-add-3 over the SIZE result bits; SIZE <= 26 keeps the value
    // below 10^8, so nothing is ever shifted out of the top digit.
    function automatic logic [31:0] bin2bcd(input logic [SIZE-1:0] bin);
        logic [31:0] bcd;
        bcd = 32'h0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            for (int d = 0; d < 8; d++) begin
                if (bcd[4*d +: 4] >= 4'd5) begin
                    bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
                end
            end
            bcd = {bcd[30:0], bin[i]};
        end
        return bcd;
    endfunction

    // Product is taken mod 2^SIZE by construction of the self-determined width.
    assign prod      = acc * cnt;
    assign last_step = (cnt <= ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.go) begin
                    state_nxt = MULT;
                end
            end
            MULT: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (!bus.go) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.curr_state = state;
        bus.done       = (state == DONE);
    end

    // Operand and accumulator are only touched on start and while iterating;
    // in DONE and on return to IDLE they hold the last answer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.go) begin
                        cnt <= bus.n;
                        acc <= ONE;
                    end
                end
                MULT: begin
                    if (!last_step) begin
                        acc <= prod;
                        cnt <= cnt - ONE;
                    end
                end
                default: begin
                    acc <= acc;
                    cnt <= cnt;
                end
            endcase
        end
    end

    assign bus.result  = acc;
    assign bus.bcd_out = bin2bcd(acc);

endmodule

// File: tb/tb_factorial_bcd.sv
// Directed bench for factorial_bcd: reset, latency, overflow, restart and
// asynchronous reset behaviour, each scenario checked against hand-computed values.
module tb_factorial_bcd;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    factorial_bcd_if #(.SIZE(8)) bus ();

    factorial_bcd #(.SIZE(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Raise go with operand nv and count rising edges (start edge included)
    // until done is seen; edges = -1 if done never arrives within the budget.
    task automatic start_and_count(input logic [7:0] nv, output int edges);
        @(negedge clk);
        bus.n  = nv;
        bus.go = 1'b1;
        edges  = -1;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic return_idle();
        @(negedge clk);
        bus.go = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.go = 1'b0;
        bus.n  = 8'd0;
        rst_n  = 1'b0;
        #12;
        n_cmp++;
        if (bus.curr_state !== 3'd0 || bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: state=%0d done=%b required state=0 done=0", bus.curr_state, bus.done);
        end
        n_cmp++;
        if (bus.result !== 8'd0 || bus.bcd_out !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_data: result=%0d bcd=%h required 0 / 00000000", bus.result, bus.bcd_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (bus.curr_state !== 3'd0 || bus.done !== 1'b0) begin
                n_bad++;
                $display("FAIL idle_hold[%0d]: state=%0d done=%b required 0/0", k, bus.curr_state, bus.done);
            end
        end
    endtask

    task automatic test_fact5_held();
        int  edges;
        bit  unstable;
        start_and_count(8'd5, edges);
        n_cmp++;
        if (edges !== 6) begin
            n_bad++;
            $display("FAIL fact5_latency: edges=%0d required 6", edges);
        end
        n_cmp++;
        if (bus.result !== 8'd120 || bus.bcd_out !== 32'h00000120) begin
            n_bad++;
            $display("FAIL fact5_value: result=%0d bcd=%h required 120 / 00000120", bus.result, bus.bcd_out);
        end
        unstable = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (bus.done !== 1'b1 || bus.curr_state !== 3'd2 ||
                bus.result !== 8'd120 || bus.bcd_out !== 32'h00000120) begin
                unstable = 1'b1;
            end
        end
        n_cmp++;
        if (unstable) begin
            n_bad++;
            $display("FAIL fact5_hold: final state=%0d done=%b result=%0d required 2/1/120", bus.curr_state, bus.done, bus.result);
        end
    endtask

    task automatic test_back_to_back();
        int edges;
        return_idle();
        n_cmp++;
        if (bus.curr_state !== 3'd0 || bus.done !== 1'b0 || bus.result !== 8'd120) begin
            n_bad++;
            $display("FAIL drop_go: state=%0d done=%b result=%0d required 0/0/120", bus.curr_state, bus.done, bus.result);
        end
        start_and_count(8'd4, edges);
        n_cmp++;
        if (edges !== 5) begin
            n_bad++;
            $display("FAIL fact4_latency: edges=%0d required 5", edges);
        end
        n_cmp++;
        if (bus.result !== 8'd24 || bus.bcd_out !== 32'h00000024) begin
            n_bad++;
            $display("FAIL fact4_value: result=%0d bcd=%h required 24 / 00000024", bus.result, bus.bcd_out);
        end
    endtask

    task automatic test_small_operands();
        int edges;
        for (int v = 0; v < 2; v++) begin
            return_idle();
            start_and_count(8'(v), edges);
            n_cmp++;
            if (edges !== 2) begin
                n_bad++;
                $display("FAIL small_latency n=%0d: edges=%0d required 2", v, edges);
            end
            n_cmp++;
            if (bus.result !== 8'd1 || bus.bcd_out !== 32'h00000001) begin
                n_bad++;
                $display("FAIL small_value n=%0d: result=%0d bcd=%h required 1 / 00000001", v, bus.result, bus.bcd_out);
            end
        end
    endtask

    task automatic test_overflow();
        int edges;
        return_idle();
        start_and_count(8'd6, edges);
        n_cmp++;
        if (edges !== 7) begin
            n_bad++;
            $display("FAIL fact6_latency: edges=%0d required 7", edges);
        end
        n_cmp++;
        if (bus.result !== 8'd208 || bus.bcd_out !== 32'h00000208) begin
            n_bad++;
            $display("FAIL fact6_value: result=%0d bcd=%h required 208 / 00000208", bus.result, bus.bcd_out);
        end
    endtask

    task automatic test_async_reset();
        int edges;
        return_idle();
        @(negedge clk);
        bus.n  = 8'd5;
        bus.go = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.curr_state !== 3'd1 || bus.result !== 8'd5) begin
            n_bad++;
            $display("FAIL mid_mult: state=%0d result=%0d required 1/5", bus.curr_state, bus.result);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.curr_state !== 3'd0 || bus.done !== 1'b0 ||
            bus.result !== 8'd0 || bus.bcd_out !== 32'h0) begin
            n_bad++;
            $display("FAIL async_reset: state=%0d done=%b result=%0d bcd=%h required 0/0/0/00000000",
                     bus.curr_state, bus.done, bus.result, bus.bcd_out);
        end
        @(negedge clk);
        bus.go = 1'b0;
        rst_n  = 1'b1;
        @(posedge clk);
        #1;
        start_and_count(8'd3, edges);
        n_cmp++;
        if (edges !== 4 || bus.result !== 8'd6 || bus.bcd_out !== 32'h00000006) begin
            n_bad++;
            $display("FAIL rerun_fact3: edges=%0d result=%0d bcd=%h required 4 / 6 / 00000006", edges, bus.result, bus.bcd_out);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_fact5_held();
        test_back_to_back();
        test_small_operands();
        test_overflow();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
